// File: rtl/tone_pkg.sv
// Shared types and default widths for the tone generator.
package tone_pkg;

    localparam int unsigned DefPeriodW = 12;
    localparam int unsigned DefDurW    = 16;

    typedef enum logic [1:0] {
        StIdle,
        StAttack,
        StSustain,
        StRelease
    } tone_state_e;

endpackage

// File: rtl/tone_phase.sv
// Tick-gated square-wave phase: sq toggles every `period` ticks.
module tone_phase
    import tone_pkg::*;
#(
    parameter int unsigned PERIOD_W = DefPeriodW
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                tick,
    input  logic                clear,
    input  logic [PERIOD_W-1:0] period,
    output logic                sq
);

    logic [PERIOD_W-1:0] r_cnt;
    logic                r_sq;

    // A zero period means "silent": clear parks sq low and ticks are ignored.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
            r_sq  <= 1'b0;
        end else if (clear) begin
            r_cnt <= '0;
            r_sq  <= (period != '0);
        end else if (tick && (period != '0)) begin
            if (r_cnt == period - 1'b1) begin
                r_cnt <= '0;
                r_sq  <= ~r_sq;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign sq = r_sq;

endmodule

// File: rtl/tone_gen.sv
// Single-note square-wave tone generator with attack/sustain/release envelope.
module tone_gen
    import tone_pkg::*;
#(
    parameter int unsigned PERIOD_W = DefPeriodW,
    parameter int unsigned DUR_W    = DefDurW
) (
    input  logic                CLOCK_50,
    input  logic                reset,
    input  logic                tick,
    input  logic                start,
    input  logic [PERIOD_W-1:0] period,
    input  logic [DUR_W-1:0]    duration,
    input  logic [3:0]          volume,
    input  logic                abort,
    output logic [7:0]          audio_out,
    output logic                busy,
    output logic                done
);

    tone_state_e         r_state;
    tone_state_e         w_state_nxt;
    logic [PERIOD_W-1:0] r_period_l;
    logic [DUR_W-1:0]    r_dur_l;
    logic [3:0]          r_vol_l;
    logic [3:0]          r_env;
    logic [3:0]          w_env_nxt;
    logic [DUR_W-1:0]    r_sus_cnt;
    logic [DUR_W-1:0]    w_sus_nxt;
    logic                r_done;
    logic                w_accept;
    logic                w_to_idle;
    logic                w_ph_clear;
    logic [PERIOD_W-1:0] w_ph_period;
    logic                w_sq;

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            r_state    <= StIdle;
            r_period_l <= '0;
            r_dur_l    <= '0;
            r_vol_l    <= '0;
            r_env      <= '0;
            r_sus_cnt  <= '0;
            r_done     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_env     <= w_env_nxt;
            r_sus_cnt <= w_sus_nxt;
            r_done    <= w_to_idle;
            if (w_accept) begin
                r_period_l <= period;
                r_dur_l    <= duration;
                r_vol_l    <= volume;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_env_nxt   = r_env;
        w_sus_nxt   = r_sus_cnt;
        w_accept    = 1'b0;
        w_to_idle   = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (start && (period != '0)) begin
                    w_accept    = 1'b1;
                    w_state_nxt = StAttack;
                    w_env_nxt   = '0;
                end
            end
            StAttack: begin
                if (abort) begin
                    w_state_nxt = StRelease;
                end else if (tick) begin
                    if (r_env < r_vol_l) w_env_nxt = r_env + 4'd1;
                    if (w_env_nxt == r_vol_l) begin
                        w_state_nxt = StSustain;
                        w_sus_nxt   = (r_dur_l == '0) ? DUR_W'(1) : r_dur_l;
                    end
                end
            end
            StSustain: begin
                if (abort) begin
                    w_state_nxt = StRelease;
                end else if (tick) begin
                    if (r_sus_cnt <= DUR_W'(1)) w_state_nxt = StRelease;
                    else                        w_sus_nxt   = r_sus_cnt - DUR_W'(1);
                end
            end
            StRelease: begin
                if (tick) begin
                    if (r_env != '0) w_env_nxt = r_env - 4'd1;
                    if (w_env_nxt == '0) begin
                        w_state_nxt = StIdle;
                        w_to_idle   = 1'b1;
                    end
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    // Phase runs on the latched period while a note is active; a zero period parks sq low.
    always_comb begin
        if (w_accept)                               w_ph_period = period;
        else if ((r_state == StIdle) || w_to_idle)  w_ph_period = '0;
        else                                        w_ph_period = r_period_l;
    end

    assign w_ph_clear = w_accept | w_to_idle;

    tone_phase #(
        .PERIOD_W(PERIOD_W)
    ) u_phase (
        .clk    (CLOCK_50),
        .reset  (reset),
        .tick   (tick),
        .clear  (w_ph_clear),
        .period (w_ph_period),
        .sq     (w_sq)
    );

    assign audio_out = w_sq ? {r_env, 4'b0000} : 8'd0;
    assign busy      = (r_state != StIdle);
    assign done      = r_done;

endmodule

// File: tb/tb_tone_gen.sv
// Self-checking bench for tone_gen: directed scenarios plus randomized notes vs a note-level model.
module tb_tone_gen;

    localparam int PW = 12;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          tick, start, abort;
    logic [PW-1:0] period;
    logic [DW-1:0] duration;
    logic [3:0]    volume;
    logic [7:0]    audio_out;
    logic          busy, done;

    int n_checks = 0;
    int n_fail   = 0;

    // Note-level model: stage 0 idle, 1 attack, 2 sustain, 3 release.
    int m_stage, m_env, m_per, m_dur, m_vol, m_ticks, m_sus_left;
    bit m_done;

    tone_gen #(
        .PERIOD_W(PW),
        .DUR_W   (DW)
    ) dut (
        .CLOCK_50  (clk),
        .reset     (reset),
        .tick      (tick),
        .start     (start),
        .period    (period),
        .duration  (duration),
        .volume    (volume),
        .abort     (abort),
        .audio_out (audio_out),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic m_reset();
        m_stage = 0; m_env = 0; m_per = 1; m_dur = 0; m_vol = 0;
        m_ticks = 0; m_sus_left = 0; m_done = 1'b0;
    endtask

    task automatic model_step(input bit st, input bit ab, input bit tk,
                              input int per, input int dur, input int vol);
        m_done = 1'b0;
        if (m_stage == 0) begin
            if (st && per != 0) begin
                m_stage = 1; m_env = 0; m_per = per; m_dur = dur; m_vol = vol; m_ticks = 0;
            end
        end else begin
            if (ab && (m_stage == 1 || m_stage == 2)) begin
                m_stage = 3;
            end else if (tk) begin
                case (m_stage)
                    1: begin
                        if (m_env < m_vol) m_env++;
                        if (m_env == m_vol) begin
                            m_stage = 2;
                            m_sus_left = (m_dur == 0) ? 1 : m_dur;
                        end
                    end
                    2: begin
                        m_sus_left--;
                        if (m_sus_left == 0) m_stage = 3;
                    end
                    default: begin
                        if (m_env > 0) m_env--;
                        if (m_env == 0) begin
                            m_stage = 0; m_done = 1'b1;
                        end
                    end
                endcase
            end
            if (tk) m_ticks++;
        end
    endtask

    function automatic int exp_audio();
        if (m_stage == 0) return 0;
        if (((m_ticks / m_per) % 2) != 0) return 0;
        return m_env * 16;
    endfunction

    function automatic bit exp_busy();
        return m_stage != 0;
    endfunction

    task automatic set_note(input int per, input int dur, input int vol);
        period = PW'(per); duration = DW'(dur); volume = 4'(vol);
    endtask

    task automatic cyc(input bit st, input bit ab, input bit tk);
        start = st; abort = ab; tick = tk;
        @(posedge clk);
        model_step(st, ab, tk, int'(period), int'(duration), int'(volume));
        #1;
        start = 1'b0; abort = 1'b0; tick = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; abort = 1'b0; tick = 1'b0;
        set_note(0, 0, 0);
        #2 reset = 1'b0;
        set_note(3, 2, 5); start = 1'b1; tick = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %0b want 0", busy);
        if (busy !== 1'b0) n_fail++;
        n_checks++; if (audio_out !== 8'd0) begin
            $display("FAIL reset_audio: got %0d want 0", audio_out); n_fail++;
        end
        n_checks++; if (done !== 1'b0) begin
            $display("FAIL reset_done: got %0b want 0", done); n_fail++;
        end
        start = 1'b0; tick = 1'b0;
        reset = 1'b1;
        m_reset();
        cyc(0, 0, 1);
    endtask

    task automatic test_basic();
        int exp_a[9] = '{16, 32, 0, 0, 0, 32, 32, 16, 0};
        set_note(3, 5, 2);
        cyc(1, 0, 1);
        n_checks++; if (busy !== 1'b1) begin
            $display("FAIL basic_busy_after_start: got %0b want 1", busy); n_fail++;
        end
        for (int k = 1; k <= 9; k++) begin
            cyc(0, 0, 1);
            n_checks++; if (audio_out !== 8'(exp_a[k-1])) begin
                $display("FAIL basic_audio t%0d: got %0d want %0d", k, audio_out, exp_a[k-1]);
                n_fail++;
            end
            n_checks++; if (busy !== (k < 9)) begin
                $display("FAIL basic_busy t%0d: got %0b want %0b", k, busy, k < 9); n_fail++;
            end
            n_checks++; if (done !== (k == 9)) begin
                $display("FAIL basic_done t%0d: got %0b want %0b", k, done, k == 9); n_fail++;
            end
        end
        cyc(0, 0, 1);
        n_checks++; if (done !== 1'b0) begin
            $display("FAIL basic_done_width: got %0b want 0", done); n_fail++;
        end
    endtask

    task automatic test_ignore();
        int exp_a[9] = '{16, 32, 0, 0, 0, 32, 32, 16, 0};
        set_note(3, 5, 2);
        cyc(1, 0, 1);
        for (int k = 1; k <= 9; k++) begin
            if (k == 4) set_note(7, 1, 9);
            cyc(k == 4, 0, 1);
            n_checks++; if (audio_out !== 8'(exp_a[k-1])) begin
                $display("FAIL ignore_audio t%0d: got %0d want %0d", k, audio_out, exp_a[k-1]);
                n_fail++;
            end
            n_checks++; if (done !== (k == 9)) begin
                $display("FAIL ignore_done t%0d: got %0b want %0b", k, done, k == 9); n_fail++;
            end
        end
    endtask

    task automatic test_abort();
        set_note(2, 10, 15);
        cyc(1, 0, 1);
        repeat (3) cyc(0, 0, 1);
        cyc(0, 1, 1);
        n_checks++; if (audio_out !== 8'(exp_audio())) begin
            $display("FAIL abort_keep_env: got %0d want %0d", audio_out, exp_audio()); n_fail++;
        end
        for (int k = 1; k <= 3; k++) begin
            cyc(0, 0, 1);
            n_checks++; if (audio_out !== 8'(exp_audio())) begin
                $display("FAIL abort_audio t%0d: got %0d want %0d", k, audio_out, exp_audio());
                n_fail++;
            end
            n_checks++; if (done !== (k == 3)) begin
                $display("FAIL abort_done t%0d: got %0b want %0b", k, done, k == 3); n_fail++;
            end
        end
    endtask

    task automatic test_zero_vol();
        set_note(1, 0, 0);
        cyc(1, 0, 1);
        for (int k = 1; k <= 3; k++) begin
            cyc(0, 0, 1);
            n_checks++; if (audio_out !== 8'd0) begin
                $display("FAIL zvol_audio t%0d: got %0d want 0", k, audio_out); n_fail++;
            end
            n_checks++; if (busy !== (k < 3) || done !== (k == 3)) begin
                $display("FAIL zvol_state t%0d: got busy=%0b done=%0b want busy=%0b done=%0b",
                         k, busy, done, k < 3, k == 3);
                n_fail++;
            end
        end
    endtask

    task automatic test_reset_mid();
        set_note(5, 5, 2);
        cyc(1, 0, 0);
        for (int i = 0; i < 14; i++) cyc(0, 0, (i % 4) == 0);
        n_checks++; if (audio_out !== 8'd32) begin
            $display("FAIL rmid_pre_audio: got %0d want 32", audio_out); n_fail++;
        end
        reset = 1'b0;
        #1;
        n_checks++; if (audio_out !== 8'd0 || busy !== 1'b0 || done !== 1'b0) begin
            $display("FAIL rmid_immediate: got audio=%0d busy=%0b done=%0b want 0 0 0",
                     audio_out, busy, done);
            n_fail++;
        end
        #1 reset = 1'b1;
        m_reset();
        for (int i = 0; i < 6; i++) begin
            cyc(0, 0, (i % 4) == 0);
            n_checks++; if (done !== 1'b0 || busy !== 1'b0) begin
                $display("FAIL rmid_no_done c%0d: got done=%0b busy=%0b want 0 0", i, done, busy);
                n_fail++;
            end
        end
        set_note(2, 1, 1);
        cyc(1, 0, 0);
        n_checks++; if (busy !== 1'b1) begin
            $display("FAIL rmid_restart: got %0b want 1", busy); n_fail++;
        end
        for (int i = 0; i < 50 && m_stage != 0; i++) cyc(0, 0, 1);
        n_checks++; if (busy !== 1'b0) begin
            $display("FAIL rmid_drain: got busy=%0b want 0", busy); n_fail++;
        end
        cyc(0, 0, 1);
    endtask

    task automatic test_period_zero();
        set_note(0, 5, 9);
        for (int k = 0; k < 5; k++) begin
            cyc(1, 0, 1);
            n_checks++; if (busy !== 1'b0 || audio_out !== 8'd0 || done !== 1'b0) begin
                $display("FAIL pzero c%0d: got busy=%0b audio=%0d done=%0b want 0 0 0",
                         k, busy, audio_out, done);
                n_fail++;
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 4000; c++) begin
            set_note($urandom_range(0, 4), $urandom_range(0, 5), $urandom_range(0, 15));
            cyc($urandom_range(0, 5) == 0, $urandom_range(0, 24) == 0, $urandom_range(0, 2) != 0);
            n_checks++; if (audio_out !== 8'(exp_audio())) begin
                $display("FAIL rand_audio c%0d: got %0d want %0d", c, audio_out, exp_audio());
                n_fail++;
            end
            n_checks++; if (busy !== exp_busy()) begin
                $display("FAIL rand_busy c%0d: got %0b want %0b", c, busy, exp_busy()); n_fail++;
            end
            n_checks++; if (done !== m_done) begin
                $display("FAIL rand_done c%0d: got %0b want %0b", c, done, m_done); n_fail++;
            end
        end
    endtask

    initial begin
        m_reset();
        test_reset();
        test_basic();
        test_ignore();
        test_abort();
        test_zero_vol();
        test_reset_mid();
        test_period_zero();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tone_gen.md
TONE_GEN -- requirements
Module: tone_gen

Interface
REQ-001 Parameter PERIOD_W, default 12: width of the half-period in ticks.
REQ-002 Parameter DUR_W, default 16: width of the sustain duration in ticks.
REQ-003 CLOCK_50  input  1  system clock; all state SHALL change on its rising edge only.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 tick  input  1  one-cycle enable pulse from the upstream tick divider; all tone/envelope progress SHALL occur only on cycles with tick=1.
REQ-006 start  input  1  request a new note; sampled every cycle.
REQ-007 period  input  PERIOD_W  square-wave half-period in ticks, latched on accepted start.
REQ-008 duration  input  DUR_W  sustain length in ticks, latched on accepted start.
REQ-009 volume  input  4  peak envelope level, latched on accepted start.
REQ-010 abort  input  1  force early release; acts on any cycle, independent of tick.
REQ-011 audio_out  output  8  unsigned sample: sq ? {env,4'b0000} : 8'd0, derived only from registers.
REQ-012 busy  output  1  high whenever state is not IDLE.
REQ-013 done  output  1  one-cycle pulse on the return to IDLE.

Function
REQ-014 States SHALL be IDLE, ATTACK, SUSTAIN, RELEASE.
REQ-015 start SHALL be accepted only in IDLE with period!=0; on acceptance: latch period/duration/volume, env=0, sq=1, phase_cnt=0, state=ATTACK, busy=1 on the next cycle.
REQ-016 start while busy, or with period=0, SHALL be ignored with no state change.
REQ-017 Phase: while busy, on each tick, phase_cnt==period_l-1 SHALL set phase_cnt=0 and toggle sq, else phase_cnt increments; the square period is 2*period_l ticks.
REQ-018 ATTACK: on each tick, env increments if env<vol_l; the state SHALL move to SUSTAIN on the tick where the updated env equals vol_l (volume=0 leaves on the first tick).
REQ-019 SUSTAIN: SHALL last exactly max(duration_l,1) ticks, then RELEASE.
REQ-020 RELEASE: on each tick, env decrements if env>0; the state SHALL move to IDLE on the tick where the updated env is 0 (immediately on the first tick if entered with env=0).
REQ-021 On entry to IDLE: done=1 for exactly one cycle, busy=0, sq=0, and audio_out=0 from that cycle.
REQ-022 abort in ATTACK or SUSTAIN SHALL move to RELEASE on that clock edge, keeping the current env; abort in RELEASE or IDLE SHALL have no effect.
REQ-023 Simultaneous start and abort in IDLE SHALL accept start.
REQ-024 Simultaneous abort and tick SHALL apply the abort only; no envelope step on that edge.
REQ-025 With tick held at 0, all registers except the abort transition SHALL hold.

Reset
REQ-026 reset low SHALL immediately force state=IDLE, env=0, sq=0, phase_cnt=0, all latched fields 0, audio_out=0, busy=0, done=0, including mid-note; no done pulse SHALL be generated.

Structure
REQ-027 Shared package tone_pkg SHALL hold the state enum and the PERIOD_W and DUR_W defaults.
REQ-028 The tick-gated phase counter and sq toggle SHALL be a sub-module tone_phase (inputs: clk, reset, tick, clear, period; output: sq).

Verification
REQ-029 tick=1 constantly; start with period=3, volume=2, duration=5 -> busy=1 after the start edge; env steps 1,2; 5 SUSTAIN ticks; env steps 1,0; done pulse after tick 9; sq toggles every 3 ticks.
REQ-030 Second start with period=7 during SUSTAIN -> ignored; period_l stays 3 and timing matches REQ-029.
REQ-031 abort at ATTACK env=3 (volume=15) -> RELEASE on the same edge; done after 3 further ticks.
REQ-032 volume=0, duration=0 -> ATTACK, SUSTAIN, and RELEASE take one tick each; done after tick 3; audio_out always 0.
REQ-033 tick every 4 cycles, reset pulsed low in SUSTAIN -> all outputs 0 immediately, no done, a new start is accepted normally afterwards.
REQ-034 start with period=0 -> busy stays 0 and no output activity.
